sample_voice: RTL and testbench
===============================

Name: sample_voice

Overview:
- Playback stage directly downstream of the SD sample feeder.
- Turns MIDI note events into feeder start/stop commands and waits for the feeder FIFO to prefill.
- Pops one 16-bit signed sample per audio tick, scales it by note velocity and applies a linear release fade.
- Emits a continuous, strobed sample stream toward the mixer/DAC.

Parameters:
CLK_DIV, 2000, clk96m cycles per audio sample (96 MHz / 48 kHz); minimum 8.
RELEASE_STEP, 1, gain decrement per audio tick during release (1..127).

Ports:
clk96m  in  1  system clock, 96 MHz
rst  in  1  synchronous, active-high reset
midi_on  in  1  one-cycle note-on pulse
midi_off  in  1  one-cycle note-off pulse
midi_id  in  8  sample code, sampled on midi_on
midi_vel  in  7  velocity 0..127, sampled on midi_on
sd_id  out  8  latched sample code to feeder
sd_note_on  out  1  one-cycle start pulse to feeder
sd_note_off  out  1  one-cycle stop pulse to feeder
sd_completed  in  1  feeder has written the last sample of the file
fifo_rd  out  1  FIFO pop strobe
fifo_data  in  16  FIFO read data, valid the cycle after fifo_rd
fifo_empty  in  1  FIFO empty
fifo_halffull  in  1  FIFO at or above half
sample_out  out  16  signed scaled sample
sample_valid  out  1  one-cycle strobe per audio tick
underrun  out  1  one-cycle pulse: tick in PLAY/RELEASE with FIFO empty and not completed
busy  out  1  high in any state except IDLE
state  out  3  IDLE=0 START=1 PREFILL=2 PLAY=3 RELEASE=4 STOP=5 DRAIN=6

Behaviour:
- Reset values:
  - All outputs 0; state IDLE; gain 0; sd_id 0.
  - Tick counter 0; it runs free from reset, independent of state.
- Tick:
  - Registered pulse when the counter equals CLK_DIV-1; the counter then wraps to 0.
  - Tick at cycle T -> sample_valid at T+3 in every state. No missing strobes.
  - Pipeline: fifo_rd at T+1 (if popping), data at T+2, registered result at T+3.
- Scaling:
  - sample_out = (fifo_data * {0,gain}) >>> 7, computed as a 16x8 signed product with arithmetic shift; result is the low 16 bits (cannot overflow).
  - gain is 7 bits.
  - Outside PLAY/RELEASE, or on underrun, sample_out = 0.
- IDLE:
  - midi_on: latch midi_id into sd_id and midi_vel into gain -> START.
  - midi_off is ignored. Simultaneous on+off: on wins.
- START: sd_note_on high exactly one cycle -> PREFILL.
- PREFILL:
  - fifo_halffull or sd_completed -> PLAY.
  - midi_off -> STOP (no audio produced).
  - Ticks here output 0.
- PLAY:
  - Each tick: if !fifo_empty, one fifo_rd pulse.
  - If fifo_empty && sd_completed -> STOP. No fifo_rd, output 0.
  - If fifo_empty && !sd_completed -> underrun pulse, output 0, stay in PLAY.
  - midi_off -> RELEASE.
- RELEASE:
  - Same pop rules as PLAY.
  - Each tick: gain = max(gain - RELEASE_STEP, 0), applied from the next tick's sample.
  - gain reaches 0 -> STOP.
  - End of file in RELEASE -> STOP.
- STOP: sd_note_off high exactly one cycle -> DRAIN.
- DRAIN:
  - fifo_rd high every cycle while !fifo_empty; the data is discarded.
  - Exit to IDLE on the first cycle fifo_empty is seen.
- midi_on outside IDLE is ignored (no retrigger). midi_off in START is held pending and honoured on entry to PREFILL.
- A pipeline in flight when leaving PLAY/RELEASE still completes its strobe. Its value is 0 if the state is no longer PLAY/RELEASE at T+2.
- fifo_rd is never asserted while fifo_empty=1.
- Reset mid-operation: immediate return to IDLE with all outputs 0. No sd_note_off is issued; the feeder shares rst.

Test Plan:
- Reset, 3*CLK_DIV cycles idle -> sample_valid period exactly CLK_DIV, sample_out=0, busy=0, state=0, no fifo_rd.
- midi_on id=0x05 vel=127; FIFO model holds 0x4000, halffull=1 -> sd_note_on single pulse, sd_id=0x05, state PREFILL->PLAY, first sample_out=0x3F80 at tick+3.
- Same with vel=64, data 0x8000 -> sample_out=0xC000; data 0x4000 -> 0x2000.
- In PLAY force fifo_empty=1, sd_completed=0 for 2 ticks -> 2 underrun pulses, sample_out=0, no fifo_rd; then refill -> playback resumes.
- vel=4, RELEASE_STEP=1, midi_off during PLAY -> gain 3,2,1,0 over 4 ticks; then STOP with one sd_note_off pulse; DRAIN pops the 5 remaining words; then IDLE.
- sd_completed=1 with FIFO draining to empty -> STOP/DRAIN/IDLE. midi_on in PLAY ignored. rst asserted in PLAY -> all outputs 0 the next cycle.

Source files
------------

// File: rtl/sample_voice_if.sv
`timescale 1ns/1ps
// Signal bundle between the voice stage, its MIDI source, the SD feeder/FIFO and the mixer.
// master = environment side, slave = sample_voice.
interface sample_voice_if;
    logic               midi_on;
    logic               midi_off;
    logic [7:0]         midi_id;
    logic [6:0]         midi_vel;
    logic [7:0]         sd_id;
    logic               sd_note_on;
    logic               sd_note_off;
    logic               sd_completed;
    logic               fifo_rd;
    logic signed [15:0] fifo_data;
    logic               fifo_empty;
    logic               fifo_halffull;
    logic signed [15:0] sample_out;
    logic               sample_valid;
    logic               underrun;
    logic               busy;
    logic [2:0]         state;

    modport master (
        output midi_on, midi_off, midi_id, midi_vel,
        output sd_completed, fifo_data, fifo_empty, fifo_halffull,
        input  sd_id, sd_note_on, sd_note_off, fifo_rd,
        input  sample_out, sample_valid, underrun, busy, state
    );

    modport slave (
        input  midi_on, midi_off, midi_id, midi_vel,
        input  sd_completed, fifo_data, fifo_empty, fifo_halffull,
        output sd_id, sd_note_on, sd_note_off, fifo_rd,
        output sample_out, sample_valid, underrun, busy, state
    );
endinterface

// File: rtl/sample_voice.sv
`timescale 1ns/1ps
// Voice playback stage: turns MIDI note events into feeder start/stop commands and emits a
// velocity-scaled, release-faded sample stream with one strobe per audio tick.
module sample_voice #(
    parameter int CLK_DIV      = 2000,
    parameter int RELEASE_STEP = 1
) (
    input  logic          clk96m,
    input  logic          rst,
    sample_voice_if.slave vif
);

    localparam int               CNT_W    = $clog2(CLK_DIV);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLK_DIV - 1);
    localparam logic [6:0]       REL_STEP = 7'(RELEASE_STEP);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        START   = 3'd1,
        PREFILL = 3'd2,
        PLAY    = 3'd3,
        RELEASE = 3'd4,
        STOP    = 3'd5,
        DRAIN   = 3'd6
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt;
    logic               vld_p0, vld_p1, vld_p2, vld_p3;
    logic               pop_p2;
    logic               underrun_p2;
    logic signed [15:0] sample_p3;
    logic [6:0]         gain;
    logic [7:0]         id_q;
    logic               off_pend;
    logic               in_play;
    logic               fifo_rd;

    // 16x8 signed product, arithmetic shift by 7; |result| < 2^15 so the low 16 bits are exact.
    function automatic logic signed [15:0] scale(input logic signed [15:0] d,
                                                 input logic [6:0]         g);
        logic signed [23:0] dx;
        logic signed [23:0] gx;
        logic signed [23:0] prod;
        dx   = {{8{d[15]}}, d};
        gx   = {17'd0, g};
        prod = dx * gx;
        return 16'(prod >>> 7);
    endfunction

    function automatic logic [6:0] fade(input logic [6:0] g);
        return (g > REL_STEP) ? (g - REL_STEP) : 7'd0;
    endfunction

    assign in_play = (state_q == PLAY) || (state_q == RELEASE);

    // p0: free-running audio tick
    always_ff @(posedge clk96m) begin
        if (rst) begin
            cnt    <= '0;
            vld_p0 <= 1'b0;
        end else begin
            vld_p0 <= (cnt == CNT_LAST);
            cnt    <= (cnt == CNT_LAST) ? '0 : cnt + CNT_W'(1);
        end
    end

    // p1: pop decision and underrun detection; p2: FIFO word arrives and is scaled
    always_ff @(posedge clk96m) begin
        if (rst) begin
            vld_p1      <= 1'b0;
            vld_p2      <= 1'b0;
            pop_p2      <= 1'b0;
            underrun_p2 <= 1'b0;
        end else begin
            vld_p1      <= vld_p0;
            vld_p2      <= vld_p1;
            pop_p2      <= vld_p1 && in_play && fifo_rd;
            underrun_p2 <= vld_p1 && in_play && vif.fifo_empty && !vif.sd_completed;
        end
    end

    // p3: registered sample and strobe toward the mixer
    always_ff @(posedge clk96m) begin
        if (rst) begin
            vld_p3    <= 1'b0;
            sample_p3 <= '0;
        end else begin
            vld_p3 <= vld_p2;
            if (vld_p2) begin
                sample_p3 <= (pop_p2 && in_play) ? scale(vif.fifo_data, gain) : '0;
            end
        end
    end

    // The release decrement lands after this tick's multiply, so it shapes the next sample.
    always_ff @(posedge clk96m) begin
        if (rst) begin
            state_q  <= IDLE;
            gain     <= '0;
            id_q     <= '0;
            off_pend <= 1'b0;
        end else begin
            state_q  <= state_d;
            off_pend <= (state_q == START) && vif.midi_off;
            if ((state_q == IDLE) && vif.midi_on) begin
                id_q <= vif.midi_id;
                gain <= vif.midi_vel;
            end else if (vld_p2 && (state_q == RELEASE)) begin
                gain <= fade(gain);
            end
        end
    end

    always_comb begin
        state_d = state_q;
        fifo_rd = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (vif.midi_on) state_d = START;
            end
            START: begin
                state_d = PREFILL;
            end
            PREFILL: begin
                if (vif.midi_off || off_pend)                 state_d = STOP;
                else if (vif.fifo_halffull || vif.sd_completed) state_d = PLAY;
            end
            PLAY, RELEASE: begin
                fifo_rd = vld_p1 && !vif.fifo_empty;
                if (vld_p1 && vif.fifo_empty && vif.sd_completed)
                    state_d = STOP;
                else if ((state_q == RELEASE) && vld_p2 && (fade(gain) == 7'd0))
                    state_d = STOP;
                else if ((state_q == PLAY) && vif.midi_off)
                    state_d = RELEASE;
            end
            STOP: begin
                state_d = DRAIN;
            end
            DRAIN: begin
                fifo_rd = !vif.fifo_empty;
                if (vif.fifo_empty) state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign vif.fifo_rd      = fifo_rd;
    assign vif.sd_note_on   = (state_q == START);
    assign vif.sd_note_off  = (state_q == STOP);
    assign vif.busy         = (state_q != IDLE);
    assign vif.state        = state_q;
    assign vif.sd_id        = id_q;
    assign vif.sample_out   = sample_p3;
    assign vif.sample_valid = vld_p3;
    assign vif.underrun     = underrun_p2;

endmodule

// File: tb/tb_sample_voice.sv
`timescale 1ns/1ps
// Scoreboard bench for sample_voice: directed note scenarios queue hand-computed samples,
// a monitor checks every strobe, its period, and counts feeder/FIFO side effects.
module tb_sample_voice;

    localparam int CLK_DIV      = 16;
    localparam int RELEASE_STEP = 1;

    logic clk96m;
    logic rst;

    sample_voice_if vif ();

    sample_voice #(.CLK_DIV(CLK_DIV), .RELEASE_STEP(RELEASE_STEP)) dut (
        .clk96m (clk96m),
        .rst    (rst),
        .vif    (vif)
    );

    int n_vec = 0;
    int n_err = 0;
    int n_pops = 0;
    int n_underrun = 0;
    int n_on = 0;
    int n_off = 0;
    int cyc = 0;
    int last_strobe = -1;
    logic signed [15:0] exp_q[$];
    logic [15:0]        fq[$];

    initial begin
        clk96m = 1'b0;
        forever #5 clk96m = ~clk96m;
    end

    initial begin
        forever begin
            @(posedge clk96m);
            cyc++;
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation still running at %0t, want finished", $time);
        $fatal(1);
    end

    task automatic check(input string name, input int act, input int req);
        n_vec++;
        if (act != req) begin
            n_err++;
            $display("FAIL %s: got %0d (0x%0h), want %0d (0x%0h)", name, act, act, req, req);
        end
    endtask

    // FIFO model: a pop seen at a clock edge presents its word just after that edge.
    initial begin
        logic pop;
        vif.fifo_data  = '0;
        vif.fifo_empty = 1'b1;
        forever begin
            @(posedge clk96m);
            pop = vif.fifo_rd;
            #1;
            if (pop && fq.size() > 0) begin
                vif.fifo_data = fq.pop_front();
                n_pops++;
            end
            vif.fifo_empty = (fq.size() == 0);
        end
    end

    // Monitor: pops one expected sample per strobe.
    initial begin
        forever begin
            @(negedge clk96m);
            if (rst) begin
                last_strobe = -1;
            end else begin
                if (vif.sd_note_on)  n_on++;
                if (vif.sd_note_off) n_off++;
                if (vif.underrun)    n_underrun++;
                if (vif.fifo_rd && vif.fifo_empty) begin
                    n_err++;
                    $display("FAIL fifo_rd_on_empty: fifo_rd=1 with fifo_empty=1 at cycle %0d", cyc);
                end
                if (vif.sample_valid) begin
                    if (last_strobe >= 0) check("strobe_period", cyc - last_strobe, CLK_DIV);
                    last_strobe = cyc;
                    if (exp_q.size() == 0) begin
                        n_err++;
                        $display("FAIL unexpected_strobe: sample_out=0x%0h at cycle %0d, want no strobe",
                                 vif.sample_out, cyc);
                    end else begin
                        check("sample_out", int'(vif.sample_out), int'(exp_q.pop_front()));
                    end
                end
            end
        end
    end

    task automatic wait_strobe();
        int k = 0;
        do begin
            @(negedge clk96m);
            k++;
        end while (!vif.sample_valid && k < 2 * CLK_DIV);
        if (!vif.sample_valid) begin
            n_err++;
            $display("FAIL strobe_timeout: no sample_valid within %0d cycles", 2 * CLK_DIV);
        end
    endtask

    task automatic step(input logic signed [15:0] e);
        exp_q.push_back(e);
        wait_strobe();
    endtask

    task automatic tick_cycle();
        @(posedge clk96m);
        #1;
    endtask

    task automatic note_on(input logic [7:0] id, input logic [6:0] vel);
        tick_cycle();
        vif.midi_id  = id;
        vif.midi_vel = vel;
        vif.midi_on  = 1'b1;
        tick_cycle();
        vif.midi_on  = 1'b0;
        vif.midi_id  = 8'hEE;
        vif.midi_vel = 7'h55;
    endtask

    task automatic note_off();
        tick_cycle();
        vif.midi_off = 1'b1;
        tick_cycle();
        vif.midi_off = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int k = 0;
        while (vif.state != 3'd0 && k < 4 * CLK_DIV) begin
            tick_cycle();
            k++;
        end
        check(name, int'(vif.state), 0);
    endtask

    task automatic start_note(input logic [7:0] id, input logic [6:0] vel, input string tag);
        note_on(id, vel);
        check({tag, "_note_on"}, int'(vif.sd_note_on), 1);
        check({tag, "_sd_id"}, int'(vif.sd_id), int'(id));
        check({tag, "_state_start"}, int'(vif.state), 1);
        tick_cycle();
        check({tag, "_state_prefill"}, int'(vif.state), 2);
        tick_cycle();
        check({tag, "_state_play"}, int'(vif.state), 3);
    endtask

    initial begin
        rst               = 1'b1;
        vif.midi_on       = 1'b0;
        vif.midi_off      = 1'b0;
        vif.midi_id       = '0;
        vif.midi_vel      = '0;
        vif.sd_completed  = 1'b0;
        vif.fifo_halffull = 1'b0;
        repeat (4) tick_cycle();
        check("rst_sample_valid", int'(vif.sample_valid), 0);
        check("rst_sample_out", int'(vif.sample_out), 0);
        check("rst_busy", int'(vif.busy), 0);
        check("rst_state", int'(vif.state), 0);
        check("rst_sd_id", int'(vif.sd_id), 0);
        check("rst_fifo_rd", int'(vif.fifo_rd), 0);
        rst = 1'b0;

        // Idle stream: zero samples at exact period, nothing popped.
        repeat (3) step(16'sh0000);
        check("idle_busy", int'(vif.busy), 0);
        check("idle_state", int'(vif.state), 0);
        check("idle_pops", n_pops, 0);

        // A: vel 127, 0x4000, then end of file.
        fq.push_back(16'h4000);
        vif.fifo_halffull = 1'b1;
        start_note(8'h05, 7'd127, "a");
        step(16'sh3F80);
        vif.sd_completed = 1'b1;
        step(16'sh0000);
        wait_idle("a_idle");
        check("a_pops", n_pops, 1);
        check("a_note_on_count", n_on, 1);
        check("a_note_off_count", n_off, 1);
        vif.sd_completed = 1'b0;
        step(16'sh0000);

        // B: vel 64, two words, two underruns, retrigger ignored, refill.
        fq.push_back(16'h8000);
        fq.push_back(16'h4000);
        start_note(8'h12, 7'd64, "b");
        step(16'shC000);
        step(16'sh2000);
        check("b_pops", n_pops, 3);
        step(16'sh0000);
        step(16'sh0000);
        check("b_underrun_count", n_underrun, 2);
        check("b_pops_hold", n_pops, 3);
        check("b_state_play", int'(vif.state), 3);
        fq.push_back(16'h4000);
        note_on(8'h77, 7'd1);
        check("b_retrig_sd_id", int'(vif.sd_id), 8'h12);
        check("b_retrig_state", int'(vif.state), 3);
        step(16'sh2000);
        check("b_retrig_note_on", n_on, 2);
        check("b_pops_refill", n_pops, 4);
        vif.sd_completed = 1'b1;
        step(16'sh0000);
        wait_idle("b_idle");
        vif.sd_completed = 1'b0;
        step(16'sh0000);

        // C: vel 4 with release fade 4,3,2,1 then drain of 5 leftover words.
        repeat (10) fq.push_back(16'h4000);
        start_note(8'h21, 7'd4, "c");
        step(16'sh0200);
        note_off();
        check("c_state_release", int'(vif.state), 4);
        step(16'sh0200);
        step(16'sh0180);
        step(16'sh0100);
        step(16'sh0080);
        wait_idle("c_idle");
        check("c_pops", n_pops, 14);
        check("c_fifo_drained", fq.size(), 0);
        check("c_note_off_count", n_off, 3);
        vif.fifo_halffull = 1'b0;
        step(16'sh0000);

        // D: prefill satisfied by end of file, play out two words.
        vif.sd_completed = 1'b1;
        fq.push_back(16'h1000);
        fq.push_back(16'h2000);
        start_note(8'h33, 7'd127, "d");
        step(16'sh0FE0);
        step(16'sh1FC0);
        step(16'sh0000);
        wait_idle("d_idle");
        check("d_pops", n_pops, 16);
        check("d_note_off_count", n_off, 4);
        vif.sd_completed = 1'b0;
        step(16'sh0000);

        // E: note-off during prefill, then note-off held pending from START.
        note_on(8'h44, 7'd100);
        tick_cycle();
        check("e_state_prefill", int'(vif.state), 2);
        note_off();
        check("e_state_stop", int'(vif.state), 5);
        check("e_note_off", int'(vif.sd_note_off), 1);
        wait_idle("e_idle");
        step(16'sh0000);
        note_on(8'h45, 7'd100);
        vif.midi_off = 1'b1;
        tick_cycle();
        vif.midi_off = 1'b0;
        check("e2_state_prefill", int'(vif.state), 2);
        tick_cycle();
        check("e2_state_stop", int'(vif.state), 5);
        wait_idle("e2_idle");
        check("e_note_off_count", n_off, 6);
        step(16'sh0000);

        // F: reset while playing.
        repeat (3) fq.push_back(16'h4000);
        vif.fifo_halffull = 1'b1;
        start_note(8'h5A, 7'd127, "f");
        step(16'sh3F80);
        tick_cycle();
        rst = 1'b1;
        tick_cycle();
        check("f_rst_state", int'(vif.state), 0);
        check("f_rst_busy", int'(vif.busy), 0);
        check("f_rst_sample_out", int'(vif.sample_out), 0);
        check("f_rst_sample_valid", int'(vif.sample_valid), 0);
        check("f_rst_sd_id", int'(vif.sd_id), 0);
        check("f_rst_fifo_rd", int'(vif.fifo_rd), 0);
        check("f_rst_note_off", int'(vif.sd_note_off), 0);
        rst = 1'b0;
        fq.delete();
        vif.fifo_halffull = 1'b0;
        step(16'sh0000);
        check("f_no_note_off", n_off, 6);
        check("exp_queue_empty", exp_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
